// File: rtl/sha_pipelined_nonce_scheduler_if.sv
// Job, core-issue and result signals around the double-SHA256 nonce scheduler.
// master is the scheduler; slave is the job source / hash core side.
interface sha_pipelined_nonce_scheduler_if;
    logic        job_valid;
    logic        job_ready;
    logic [7:0]  job_id;
    logic [31:0] job_nonce_start;
    logic [31:0] job_target_mask;
    logic        abort;
    logic        core_valid;
    logic        core_newblock;
    logic [31:0] core_nonce;
    logic        hash_valid;
    logic [31:0] hash_word;
    logic        found_valid;
    logic [31:0] found_nonce;
    logic [7:0]  found_job_id;
    logic        done;
    logic        done_found;

    modport master (
        input  job_valid, job_id, job_nonce_start, job_target_mask,
        input  abort, hash_valid, hash_word,
        output job_ready, core_valid, core_newblock, core_nonce,
        output found_valid, found_nonce, found_job_id, done, done_found
    );

    modport slave (
        output job_valid, job_id, job_nonce_start, job_target_mask,
        output abort, hash_valid, hash_word,
        input  job_ready, core_valid, core_newblock, core_nonce,
        input  found_valid, found_nonce, found_job_id, done, done_found
    );
endinterface

// File: rtl/sha_pipelined_nonce_scheduler.sv
// Issues one nonce per cycle into a fixed-latency double-SHA256 core,
// reports the first hash under the target mask and drains before the next job.
module sha_pipelined_nonce_scheduler #(
    parameter int unsigned PROCESSORINDEX = 0,
    parameter int unsigned NUMPROCESSORS  = 1,
    parameter int unsigned LATENCY        = 131
) (
    input logic clk,
    input logic rst,
    sha_pipelined_nonce_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q;
    logic [LATENCY-1:0]  inflight_q;
    logic [31:0]         issue_q;
    logic [31:0]         result_q;
    logic [31:0]         mask_q;
    logic [7:0]          id_q;
    logic                win_q;
    logic                first_q;
    logic                found_q;
    logic [31:0]         found_nonce_q;
    logic [7:0]          found_id_q;

    logic                hv_ok;
    logic                hit;
    logic                issue;
    logic                last;
    logic                empty;
    logic [32:0]         issue_sum;
    logic [31:0]         start_nonce;

    // The tail bit of inflight_q says a real candidate is due back this cycle;
    // anything else on hash_valid is a core fault and is dropped.
    assign hv_ok       = bus.hash_valid && inflight_q[LATENCY-1];
    assign hit         = hv_ok && ((bus.hash_word & mask_q) == 32'd0) && !win_q;
    assign issue       = (state_q == RUN) && !bus.abort && !hit;
    assign issue_sum   = {1'b0, issue_q} + 33'(NUMPROCESSORS);
    assign last        = issue_sum[32];
    assign empty       = (inflight_q == '0);
    assign start_nonce = bus.job_nonce_start + 32'(PROCESSORINDEX);

    assign bus.job_ready     = (state_q == IDLE);
    assign bus.core_valid    = issue;
    assign bus.core_newblock = issue && first_q;
    assign bus.core_nonce    = issue_q;
    assign bus.found_valid   = found_q;
    assign bus.found_nonce   = found_nonce_q;
    assign bus.found_job_id  = found_id_q;
    assign bus.done          = (state_q == DRAIN) && empty;
    assign bus.done_found    = (state_q == DRAIN) && empty && win_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            inflight_q    <= '0;
            issue_q       <= 32'd0;
            result_q      <= 32'd0;
            mask_q        <= 32'd0;
            id_q          <= 8'd0;
            win_q         <= 1'b0;
            first_q       <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= 32'd0;
            found_id_q    <= 8'd0;
        end else begin
            inflight_q <= {inflight_q[LATENCY-2:0], issue};
            found_q    <= hit;
            if (hit) begin
                found_nonce_q <= result_q;
                found_id_q    <= id_q;
                win_q         <= 1'b1;
            end
            // Results return in issue order, so a counter replaces a nonce delay line.
            if (hv_ok) begin
                result_q <= result_q + 32'(NUMPROCESSORS);
            end
            unique case (state_q)
                IDLE: begin
                    if (bus.job_valid) begin
                        id_q     <= bus.job_id;
                        mask_q   <= bus.job_target_mask;
                        issue_q  <= start_nonce;
                        result_q <= start_nonce;
                        first_q  <= 1'b1;
                        win_q    <= 1'b0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    first_q <= 1'b0;
                    if (issue) begin
                        issue_q <= issue_sum[31:0];
                    end
                    if (!issue || last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        win_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha_pipelined_nonce_scheduler.sv
// Directed bench: two scheduler instances (stride 1 and stride 4) with
// a behavioural 4-cycle hash core model behind each.
module tb_sha_pipelined_nonce_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha_pipelined_nonce_scheduler_if ia ();
    sha_pipelined_nonce_scheduler_if ib ();

    sha_pipelined_nonce_scheduler #(
        .PROCESSORINDEX(0), .NUMPROCESSORS(1), .LATENCY(4)
    ) dut_a (.clk(clk), .rst(rst), .bus(ia));

    sha_pipelined_nonce_scheduler #(
        .PROCESSORINDEX(2), .NUMPROCESSORS(4), .LATENCY(4)
    ) dut_b (.clk(clk), .rst(rst), .bus(ib));

    function automatic logic [31:0] hfun(input logic [31:0] n, input int m);
        if (m == 0) return 32'h1;
        if (n == 32'h10) return 32'h00ABCDEF;
        if (n == 32'h12) return 32'h00000001;
        return 32'hFFFFFFFF;
    endfunction

    // core models: results come back exactly 4 cycles after issue
    int          a_mode = 0;
    logic [3:0]  a_hv = 4'd0;
    logic [31:0] a_hn [4];
    logic [3:0]  b_hv = 4'd0;
    logic [31:0] b_hn [4];

    always @(posedge clk) begin
        a_hv <= {a_hv[2:0], ia.core_valid};
        b_hv <= {b_hv[2:0], ib.core_valid};
        a_hn[0] <= ia.core_nonce;
        b_hn[0] <= ib.core_nonce;
        for (int i = 1; i < 4; i++) begin
            a_hn[i] <= a_hn[i-1];
            b_hn[i] <= b_hn[i-1];
        end
    end

    assign ia.hash_valid = a_hv[3];
    assign ia.hash_word  = hfun(a_hn[3], a_mode);
    assign ib.hash_valid = b_hv[3];
    assign ib.hash_word  = hfun(b_hn[3], 0);

    // monitors
    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    int          a_nb = 0, a_nb_cyc = 0, a_found = 0, a_found_cyc = 0;
    int          a_done = 0, a_done_cyc = 0, a_acc = 0;
    logic [31:0] a_nb_nonce = 0, a_found_nonce = 0;
    logic [7:0]  a_found_id = 0;
    logic        a_done_found = 0, a_ready_at_done = 0;
    int          b_nb = 0, b_found = 0, b_done = 0, b_done_cyc = 0, b_acc = 0;

    always @(negedge clk) begin
        if (ia.core_valid) a_q.push_back(ia.core_nonce);
        if (ia.core_newblock) begin
            a_nb++;
            a_nb_cyc = cyc;
            a_nb_nonce = ia.core_nonce;
        end
        if (ia.found_valid) begin
            a_found++;
            a_found_cyc = cyc;
            a_found_nonce = ia.found_nonce;
            a_found_id = ia.found_job_id;
        end
        if (ia.done) begin
            a_done++;
            a_done_cyc = cyc;
            a_done_found = ia.done_found;
            a_ready_at_done = ia.job_ready;
        end
        if (ia.job_valid && ia.job_ready) a_acc = cyc;
        if (ib.core_valid) b_q.push_back(ib.core_nonce);
        if (ib.core_newblock) b_nb++;
        if (ib.found_valid) b_found++;
        if (ib.done) begin
            b_done++;
            b_done_cyc = cyc;
        end
        if (ib.job_valid && ib.job_ready) b_acc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit use_b, input int n0);
        int i = 0;
        while (((use_b ? b_done : a_done) == n0) && i < 300) begin
            @(posedge clk);
            i++;
        end
        #1;
        chk("done_seen", 32'((use_b ? b_done : a_done) - n0), 32'd1);
    endtask

    task automatic start_a(input logic [7:0] id, input logic [31:0] s, input logic [31:0] m);
        ia.job_id = id;
        ia.job_nonce_start = s;
        ia.job_target_mask = m;
        ia.job_valid = 1'b1;
        @(posedge clk); #1;
        ia.job_valid = 1'b0;
    endtask

    task automatic start_b(input logic [31:0] s);
        ib.job_id = 8'h22;
        ib.job_nonce_start = s;
        ib.job_target_mask = 32'hFFFFFFFF;
        ib.job_valid = 1'b1;
        @(posedge clk); #1;
        ib.job_valid = 1'b0;
    endtask

    initial begin
        int q0, n0, f0, nb0, d1;
        ia.job_valid = 0; ia.job_id = 0; ia.job_nonce_start = 0;
        ia.job_target_mask = 0; ia.abort = 0;
        ib.job_valid = 0; ib.job_id = 0; ib.job_nonce_start = 0;
        ib.job_target_mask = 0; ib.abort = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ia.job_ready), 32'd1);
        chk("rst_core_valid", 32'(ia.core_valid), 32'd0);
        chk("rst_found", 32'(ia.found_valid), 32'd0);
        chk("rst_found_nonce", ia.found_nonce, 32'd0);
        chk("rst_done", 32'(ia.done), 32'd0);
        chk("rst_b_ready", 32'(ib.job_ready), 32'd1);
        @(posedge clk); #1;

        // T1: top-of-range run, no win
        a_mode = 0; q0 = a_q.size(); n0 = a_done; nb0 = a_nb;
        start_a(8'h11, 32'hFFFFFFFC, 32'hFFFFFFFF);
        wait_done(0, n0);
        chk("t1_count", 32'(a_q.size() - q0), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("t1_nonce", a_q[q0+i], 32'hFFFFFFFC + 32'(i));
        chk("t1_newblock_cnt", 32'(a_nb - nb0), 32'd1);
        chk("t1_newblock_nonce", a_nb_nonce, 32'hFFFFFFFC);
        chk("t1_done_lat", 32'(a_done_cyc - a_acc), 32'd9);
        chk("t1_done_found", 32'(a_done_found), 32'd0);
        chk("t1_ready_at_done", 32'(a_ready_at_done), 32'd0);
        chk("t1_no_found", 32'(a_found), 32'd0);

        // T2: stride 4, slot 2, aborted early then run to the top
        q0 = b_q.size(); n0 = b_done;
        start_b(32'h0);
        repeat (3) @(posedge clk);
        #1 ib.abort = 1'b1;
        @(posedge clk); #1 ib.abort = 1'b0;
        wait_done(1, n0);
        chk("t2_count", 32'(b_q.size() - q0), 32'd3);
        chk("t2_nonce0", b_q[q0], 32'd2);
        chk("t2_nonce1", b_q[q0+1], 32'd6);
        chk("t2_nonce2", b_q[q0+2], 32'd10);
        chk("t2_abort_lat", 32'(b_done_cyc - b_acc), 32'd8);
        @(posedge clk); #1;
        q0 = b_q.size(); n0 = b_done;
        start_b(32'hFFFFFFF0);
        wait_done(1, n0);
        chk("t2_top_count", 32'(b_q.size() - q0), 32'd4);
        chk("t2_top_first", b_q[q0], 32'hFFFFFFF2);
        chk("t2_top_last", b_q[b_q.size()-1], 32'hFFFFFFFE);
        chk("t2_top_lat", 32'(b_done_cyc - b_acc), 32'd9);
        chk("t2_newblocks", 32'(b_nb), 32'd2);
        chk("t2_no_found", 32'(b_found), 32'd0);

        // T3: first win at 0x10, later match at 0x12 ignored
        @(posedge clk); #1;
        a_mode = 1; q0 = a_q.size(); n0 = a_done; f0 = a_found;
        start_a(8'h5A, 32'h0000000C, 32'hFF000000);
        wait_done(0, n0);
        chk("t3_found_cnt", 32'(a_found - f0), 32'd1);
        chk("t3_found_nonce", a_found_nonce, 32'h10);
        chk("t3_found_id", 32'(a_found_id), 32'h5A);
        chk("t3_found_lat", 32'(a_found_cyc - a_acc), 32'd10);
        chk("t3_issue_cnt", 32'(a_q.size() - q0), 32'd8);
        chk("t3_done_lat", 32'(a_done_cyc - a_acc), 32'd13);
        chk("t3_done_found", 32'(a_done_found), 32'd1);

        // T4: abort on the 5th run cycle
        @(posedge clk); #1;
        a_mode = 0; q0 = a_q.size(); n0 = a_done; f0 = a_found;
        start_a(8'h33, 32'h00000100, 32'hFFFFFFFF);
        repeat (4) @(posedge clk);
        #1 ia.abort = 1'b1;
        @(posedge clk); #1 ia.abort = 1'b0;
        wait_done(0, n0);
        chk("t4_count", 32'(a_q.size() - q0), 32'd4);
        chk("t4_last", a_q[a_q.size()-1], 32'h103);
        chk("t4_done_lat", 32'(a_done_cyc - a_acc), 32'd9);
        chk("t4_done_found", 32'(a_done_found), 32'd0);

        // T5: reset mid-run with a winning result still in the core
        @(posedge clk); #1;
        a_mode = 1; n0 = a_done; f0 = a_found;
        start_a(8'h44, 32'h0000000E, 32'hFF000000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_ready", 32'(ia.job_ready), 32'd1);
        chk("t5_core_valid", 32'(ia.core_valid), 32'd0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_found", 32'(a_found - f0), 32'd0);
        chk("t5_no_done", 32'(a_done - n0), 32'd0);
        a_mode = 0; q0 = a_q.size(); nb0 = a_nb;
        start_a(8'h45, 32'hFFFFFFFE, 32'hFFFFFFFF);
        wait_done(0, n0);
        chk("t5_new_count", 32'(a_q.size() - q0), 32'd2);
        chk("t5_new_first", a_q[q0], 32'hFFFFFFFE);
        chk("t5_new_nb", 32'(a_nb - nb0), 32'd1);
        chk("t5_new_lat", 32'(a_done_cyc - a_acc), 32'd7);
        chk("t5_new_done_found", 32'(a_done_found), 32'd0);

        // T6: job_valid held high, two back-to-back jobs
        @(posedge clk); #1;
        q0 = a_q.size(); n0 = a_done; nb0 = a_nb;
        ia.job_id = 8'h66;
        ia.job_nonce_start = 32'hFFFFFFFE;
        ia.job_target_mask = 32'hFFFFFFFF;
        ia.job_valid = 1'b1;
        wait_done(0, n0);
        d1 = a_done_cyc;
        wait_done(0, n0 + 1);
        ia.job_valid = 1'b0;
        chk("t6_gap", 32'(a_nb_cyc - d1), 32'd2);
        chk("t6_acc", 32'(a_acc - d1), 32'd1);
        chk("t6_nb", 32'(a_nb - nb0), 32'd2);
        chk("t6_count", 32'(a_q.size() - q0), 32'd4);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle_ready", 32'(ia.job_ready), 32'd1);
        chk("t6_idle_valid", 32'(ia.core_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sha_pipelined_nonce_scheduler.md
# sha_pipelined_nonce_scheduler

Work sequencer for one fully pipelined double-SHA256 core. It accepts a job (block header context plus starting nonce) and issues one nonce per cycle into the core. It tracks in-flight candidates across the core's fixed latency and tests each double hash against a difficulty mask. It reports the first winning nonce and then drains the pipeline, so the next job never mixes with stale results.

## Interface
- PROCESSORINDEX, 0, this core's slot; nonces issued are ≡ PROCESSORINDEX mod NUMPROCESSORS relative to job_nonce_start
- NUMPROCESSORS, 1, nonce stride (number of parallel cores)
- LATENCY, 131, cycles from core_valid=1 to the matching hash_valid=1; ≥2
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  scheduler can accept a job
- job_id  in  8  tag returned with results
- job_nonce_start  in  32  first nonce before the PROCESSORINDEX offset
- job_target_mask  in  32  hash word bits that must all be zero for a win
- abort  in  1  stop the current job
- core_valid  out  1  candidate issued this cycle
- core_newblock  out  1  first candidate of a job (high with core_valid)
- core_nonce  out  32  nonce issued
- hash_valid  in  1  core output valid; must equal core_valid delayed LATENCY cycles
- hash_word  in  32  most-significant doublehash word
- found_valid  out  1  one-cycle pulse, winning nonce
- found_nonce  out  32  winning nonce
- found_job_id  out  8  tag of winning job
- done  out  1  one-cycle pulse, job fully retired
- done_found  out  1  high with done if the job produced found_valid

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: job_ready=1. On job_valid&&job_ready, latch job_id and target_mask. Set issue_nonce = result_nonce = job_nonce_start + PROCESSORINDEX (32-bit wrap). Go to RUN.
- RUN: each cycle, core_valid=1 and core_nonce=issue_nonce. core_newblock=1 on the first RUN cycle only.
  - issue_nonce advances by NUMPROCESSORS using a 33-bit add.
  - A carry out marks the current nonce as the last one. Go to DRAIN after issuing it. A nonce never wraps past 0xFFFFFFFF.
- RUN→DRAIN also occurs on abort=1 (the nonce in that cycle is not issued) or on a found event. core_valid=0 in that cycle.
- In-flight tracking: LATENCY-bit shift register of issued-valid bits.
  - result_nonce advances by NUMPROCESSORS on each hash_valid, so the nonce needs no delay line.
- Check: when hash_valid=1 and (hash_word & target_mask)==0 and no win yet this job:
  - next cycle found_valid=1, found_nonce=result_nonce, found_job_id=job_id;
  - set a sticky win flag.
  - Later matches in the same job are ignored.
- DRAIN: core_valid=0. Results are still checked, so a win can be reported while draining. When the shift register is empty, pulse done with done_found=win flag, clear the flag, and go to IDLE.
- abort in IDLE or DRAIN is ignored.
- hash_valid while the shift register shows no issued candidate is a core fault. Ignore it: no found, no result_nonce advance.

## Timing
- Reset: state IDLE, shift register cleared, win flag 0. All outputs 0 except job_ready=1.
  - rst mid-job discards all in-flight work; no done is emitted.
- First core_valid occurs the cycle after job acceptance.
- Throughput: one nonce per cycle in RUN.
- found_valid asserts 1 cycle after the matching hash_valid.
- done asserts the cycle after the last in-flight result retires. For an uninterrupted job of N nonces, done comes N+LATENCY+1 cycles after acceptance.
- A found and the last issue in the same cycle both send RUN to DRAIN. No extra nonce is issued.
- A found from the final result in the same cycle the pipe empties: found_valid and done assert together, with done_found=1.
- job_ready=0 from acceptance until the cycle after done.

## Test plan
- LATENCY=4, NUMPROCESSORS=1, PROCESSORINDEX=0, start 0xFFFFFFFC, mask 0xFFFFFFFF, hash_word always 1 → core_nonce 0xFFFFFFFC..0xFFFFFFFF (4 issues, core_newblock only on the first); done at cycle 9 after acceptance, done_found=0.
- NUMPROCESSORS=4, PROCESSORINDEX=2, start 0 → core_nonce sequence 2, 6, 10, …; the last nonce issued is 0xFFFFFFFE (start near the top to shorten the run).
- Mask 0xFF000000; model returns hash_word=0x00ABCDEF for nonce 0x10 and 0x00000001 for nonce 0x12 → exactly one found_valid with found_nonce=0x10. Issuing stops, later results are discarded, and done asserts with done_found=1.
- abort asserted on the 5th RUN cycle → exactly 4 nonces issued. done follows the drain of those 4 results, with done_found=0.
- rst asserted mid-RUN with results in flight → next cycle job_ready=1 and core_valid=0. No found or done appears from the old job. A new job then restarts cleanly.
- job_valid held high continuously → back-to-back jobs, with core_newblock exactly once per job. The new job's first core_valid comes 2 cycles after the previous done.
